result_bus_arbiter: RTL and testbench
=====================================

RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
- REQ-001: Parameter NUM_UNITS, default 4, is the number of execution-unit result ports arbitrated (legal range 2..8).
- REQ-002: Parameter RS_ID_WIDTH, default 5, is the reservation-station ID width; it matches all attached wrappers.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, asynchronous assertion, active-low.
- REQ-005: unit_valid  input  NUM_UNITS  per-unit result valid.
- REQ-006: unit_ready  output  NUM_UNITS  per-unit grant/ready.
- REQ-007: unit_rs_id  input  NUM_UNITS x RS_ID_WIDTH  per-unit producing RS ID.
- REQ-008: unit_reg_addr  input  NUM_UNITS x 5  per-unit destination GPR.
- REQ-009: unit_result  input  NUM_UNITS x 32  per-unit result value.
- REQ-010: unit_cr0_xer  input  NUM_UNITS x cond_exception_t  per-unit CR0/XER status.
- REQ-011: cdb_valid  output  1  broadcast valid; drives update_op_valid and update_xer_valid of all wrappers.
- REQ-012: cdb_rs_id  output  RS_ID_WIDTH  broadcast RS ID.
- REQ-013: cdb_reg_addr  output  5  broadcast destination GPR.
- REQ-014: cdb_result  output  32  broadcast result value.
- REQ-015: cdb_cr0_xer  output  cond_exception_t  broadcast CR0/XER status.

Function
- REQ-016: Units follow ready/valid: a transfer occurs on a rising edge where unit_valid[i] and unit_ready[i] are both 1.
- REQ-017: unit_ready is combinational from unit_valid and the priority pointer; at most one bit is 1 per cycle (one-hot or zero).
- REQ-018: unit_ready[i] is 1 only when unit_valid[i] is 1; with no valid unit, unit_ready is all 0.
- REQ-019: The broadcast is valid-only (no backpressure); every grant is accepted the same cycle.
- REQ-020: Latency: a unit granted in cycle N appears on cdb_* with cdb_valid=1 in cycle N+1 (registered outputs).
- REQ-021: In a cycle with no grant, cdb_valid is 0 in the next cycle; cdb_rs_id/reg_addr/result/cr0_xer hold their last values.
- REQ-022: Back-to-back grants yield cdb_valid=1 on consecutive cycles with no bubble.
- REQ-023: The priority pointer last_grant (width ceil(log2 NUM_UNITS)) updates to the granted index on every grant and holds otherwise.
- REQ-024: The search starts at (last_grant+1) mod NUM_UNITS and wraps from NUM_UNITS-1 to 0.
- REQ-025: A unit that keeps valid high is granted within NUM_UNITS cycles (no starvation) when round-robin is compiled in.
- REQ-026: Input fields are sampled only from the granted unit on the grant edge; inputs of non-granted units are ignored.

Reset
- REQ-027: While rst=0: cdb_valid=0, cdb_rs_id=0, cdb_reg_addr=0, cdb_result=0, cdb_cr0_xer=0, last_grant=NUM_UNITS-1 (unit 0 first).
- REQ-028: unit_ready is 0 while rst=0 regardless of unit_valid.
- REQ-029: Reset asserted mid-broadcast clears cdb_valid immediately; the in-flight result is dropped (upstream flush accompanies it).
- REQ-030: After rst deasserts, the first grant takes effect on the first rising edge with rst=1.

Configuration
- REQ-031: Macro RESULT_BUS_ROUND_ROBIN_EN defined: round-robin arbitration per REQ-023..REQ-025.
- REQ-032: Macro not defined: fixed priority, lowest valid index wins; last_grant is not implemented; REQ-025 is waived.

Verification
- REQ-033: Reset then only unit_valid[2]=1 with rs_id=7, result=0xDEADBEEF -> unit_ready=0100 the same cycle; next cycle cdb_valid=1, cdb_rs_id=7, cdb_result=0xDEADBEEF.
- REQ-034: All four units held valid for 8 cycles (RR build) -> grant order 0,1,2,3,0,1,2,3; cdb_valid=1 on all cycles 2..9.
- REQ-035: Same stimulus, fixed-priority build -> unit 0 granted all 8 cycles; unit_ready[1..3] stay 0.
- REQ-036: last_grant=3, units 0 and 3 valid -> unit 0 granted (wrap-around); next cycle unit 3 granted.
- REQ-037: Single grant then all valid low -> cdb_valid 1 for exactly one cycle; cdb_result holds its value afterward.
- REQ-038: rst pulled low while cdb_valid=1 -> cdb_valid=0 before the next clock edge; after release, unit 0 has first priority.

Source files
------------

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: grants one execution unit per cycle onto the registered CDB.
// Define RESULT_BUS_ROUND_ROBIN_EN for round-robin; default build is fixed priority.
package result_bus_pkg;
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic ov;
    logic ca;
  } cond_exception_t;
endpackage

module result_bus_arbiter
  import result_bus_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_UNITS-1:0]                  unit_valid,
  output logic [NUM_UNITS-1:0]                  unit_ready,
  input  logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0] unit_rs_id,
  input  logic [NUM_UNITS-1:0][4:0]             unit_reg_addr,
  input  logic [NUM_UNITS-1:0][31:0]            unit_result,
  input  cond_exception_t [NUM_UNITS-1:0]       unit_cr0_xer,
  output logic                                  cdb_valid,
  output logic [RS_ID_WIDTH-1:0]                cdb_rs_id,
  output logic [4:0]                            cdb_reg_addr,
  output logic [31:0]                           cdb_result,
  output cond_exception_t                       cdb_cr0_xer
);

  localparam int PW = $clog2(NUM_UNITS);
  localparam logic [PW-1:0] LAST = PW'(NUM_UNITS - 1);

  logic [PW-1:0] start;
  logic [PW-1:0] cidx;
  logic [PW-1:0] gidx;
  logic          any;

`ifdef RESULT_BUS_ROUND_ROBIN_EN
  logic [PW-1:0] last_grant;

  // Reset to the top index so unit 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= LAST;
    end else if (any) begin
      last_grant <= gidx;
    end
  end

  assign start = (last_grant == LAST) ? '0 : last_grant + 1'b1;
`else
  assign start = '0;
`endif

  // Circular search from start; first valid unit wins.
  always_comb begin
    unit_ready = '0;
    gidx       = '0;
    any        = 1'b0;
    cidx       = start;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (rst && !any && unit_valid[cidx]) begin
        unit_ready[cidx] = 1'b1;
        gidx             = cidx;
        any              = 1'b1;
      end
      cidx = (cidx == LAST) ? '0 : cidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid    <= 1'b0;
      cdb_rs_id    <= '0;
      cdb_reg_addr <= '0;
      cdb_result   <= '0;
      cdb_cr0_xer  <= '0;
    end else begin
      cdb_valid <= any;
      if (any) begin
        cdb_rs_id    <= unit_rs_id[gidx];
        cdb_reg_addr <= unit_reg_addr[gidx];
        cdb_result   <= unit_result[gidx];
        cdb_cr0_xer  <= unit_cr0_xer[gidx];
      end
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Randomized self-checking bench for result_bus_arbiter against a behavioural model.
// Build with RESULT_BUS_ROUND_ROBIN_EN to check the round-robin variant.
module tb_result_bus_arbiter;
  import result_bus_pkg::*;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int CW = $bits(cond_exception_t);
  localparam int BW = 1 + W + 5 + 32 + CW;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N-1:0]            unit_valid;
  logic [N-1:0]            unit_ready;
  logic [N-1:0][W-1:0]     unit_rs_id;
  logic [N-1:0][4:0]       unit_reg_addr;
  logic [N-1:0][31:0]      unit_result;
  cond_exception_t [N-1:0] unit_cr0_xer;
  logic                    cdb_valid;
  logic [W-1:0]            cdb_rs_id;
  logic [4:0]              cdb_reg_addr;
  logic [31:0]             cdb_result;
  cond_exception_t         cdb_cr0_xer;

  result_bus_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .unit_valid(unit_valid),
    .unit_ready(unit_ready),
    .unit_rs_id(unit_rs_id),
    .unit_reg_addr(unit_reg_addr),
    .unit_result(unit_result),
    .unit_cr0_xer(unit_cr0_xer),
    .cdb_valid(cdb_valid),
    .cdb_rs_id(cdb_rs_id),
    .cdb_reg_addr(cdb_reg_addr),
    .cdb_result(cdb_result),
    .cdb_cr0_xer(cdb_cr0_xer)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int              m_lg;
  logic            m_valid;
  logic [W-1:0]    m_rs;
  logic [4:0]      m_reg;
  logic [31:0]     m_res;
  cond_exception_t m_cr;

  logic [N-1:0]  er;
  logic [BW-1:0] got;
  logic [BW-1:0] exp;

  function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v);
`ifdef RESULT_BUS_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int i = (m_lg + k) % N;
      if (v[i]) return N'(1) << i;
    end
    return '0;
`else
    return v & (~v + 1'b1);
`endif
  endfunction

  task automatic m_reset();
    m_lg    = N - 1;
    m_valid = 1'b0;
    m_rs    = '0;
    m_reg   = '0;
    m_res   = '0;
    m_cr    = '0;
  endtask

  task automatic m_edge(input logic [N-1:0] g1h);
    m_valid = |g1h;
    for (int i = 0; i < N; i++) begin
      if (g1h[i]) begin
        m_lg  = i;
        m_rs  = unit_rs_id[i];
        m_reg = unit_reg_addr[i];
        m_res = unit_result[i];
        m_cr  = unit_cr0_xer[i];
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] v);
    unit_valid = v;
    for (int i = 0; i < N; i++) begin
      unit_rs_id[i]    = W'($urandom);
      unit_reg_addr[i] = 5'($urandom);
      unit_result[i]   = $urandom;
      unit_cr0_xer[i]  = cond_exception_t'(CW'($urandom));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive('1);
    #2;
    checks++;
    if (unit_ready !== '0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=%b", unit_ready, {N{1'b0}});
    end
    @(posedge clk); #1;
    got = {cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_cdb got=%h exp=0", got);
    end
    m_reset();
    rst = 1'b1;
  endtask

  task automatic test_single();
    drive(4'b0100);
    unit_rs_id[2]  = 5'd7;
    unit_result[2] = 32'hDEADBEEF;
    #2;
    checks++;
    if (unit_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready got=%b exp=0100", unit_ready);
    end
    m_edge(4'b0100);
    @(posedge clk); #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_rs_id !== 5'd7 || cdb_result !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_cdb got=%b/%0d/%h exp=1/7/deadbeef",
               cdb_valid, cdb_rs_id, cdb_result);
    end
  endtask

  task automatic test_all_valid();
    logic [N-1:0] eo;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_reset();
    for (int k = 0; k < 8; k++) begin
      drive('1);
      #2;
`ifdef RESULT_BUS_ROUND_ROBIN_EN
      eo = N'(1) << (k % N);
`else
      eo = N'(1);
`endif
      checks++;
      if (unit_ready !== eo) begin
        failures++;
        $display("FAIL all_valid_order cyc=%0d got=%b exp=%b", k, unit_ready, eo);
      end
      m_edge(eo);
      @(posedge clk); #1;
      got = {cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer};
      exp = {m_valid, m_rs, m_reg, m_res, m_cr};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL all_valid_cdb cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] pat [3];
    pat[0] = 4'b1000;
    pat[1] = 4'b1001;
    pat[2] = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      drive(pat[k]);
      #2;
      er = exp_ready(pat[k]);
      checks++;
      if (unit_ready !== er) begin
        failures++;
        $display("FAIL wrap_ready cyc=%0d got=%b exp=%b", k, unit_ready, er);
      end
      m_edge(er);
      @(posedge clk); #1;
      got = {cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer};
      exp = {m_valid, m_rs, m_reg, m_res, m_cr};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL wrap_cdb cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_idle_hold();
    logic [N-1:0] v;
    for (int k = 0; k < 4; k++) begin
      v = (k == 0) ? N'(1) << $urandom_range(N - 1) : '0;
      drive(v);
      #2;
      er = exp_ready(v);
      checks++;
      if (unit_ready !== er) begin
        failures++;
        $display("FAIL idle_ready cyc=%0d got=%b exp=%b", k, unit_ready, er);
      end
      m_edge(er);
      @(posedge clk); #1;
      got = {cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer};
      exp = {m_valid, m_rs, m_reg, m_res, m_cr};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int k = 0; k < 300; k++) begin
      v = N'($urandom);
      drive(v);
      #2;
      er = exp_ready(v);
      checks++;
      if (unit_ready !== er) begin
        failures++;
        $display("FAIL random_ready cyc=%0d v=%b got=%b exp=%b", k, v, unit_ready, er);
      end
      m_edge(er);
      @(posedge clk); #1;
      got = {cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer};
      exp = {m_valid, m_rs, m_reg, m_res, m_cr};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_cdb cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive('1);
    #2;
    er = exp_ready('1);
    m_edge(er);
    @(posedge clk); #1;
    checks++;
    if (cdb_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_valid got=%b exp=1", cdb_valid);
    end
    rst = 1'b0;
    #1;
    got = {cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer};
    checks++;
    if (got !== '0 || unit_ready !== '0) begin
      failures++;
      $display("FAIL mid_reset_clear got=%h ready=%b exp=0/0", got, unit_ready);
    end
    m_reset();
    #1;
    rst = 1'b1;
    drive('1);
    #1;
    checks++;
    if (unit_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_first_prio got=%b exp=0001", unit_ready);
    end
    m_edge(4'b0001);
    @(posedge clk); #1;
    got = {cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer};
    exp = {m_valid, m_rs, m_reg, m_res, m_cr};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL mid_first_cdb got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    m_reset();
    drive('0);
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_idle_hold();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
